// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings and FSM states.
package alu_pkg;

    // Single-cycle opcodes
    localparam logic [2:0] OP_FWD   = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    // Iterative opcodes (one bit per cycle)
    localparam logic [2:0] OP_ROR   = 3'b100;
    localparam logic [2:0] OP_MUL   = 3'b101;
    localparam logic [2:0] OP_SRA   = 3'b110;
    localparam logic [2:0] OP_SHIFT = 3'b111;

    // Control FSM: IDLE accepts START, RUN steps the iterative datapath
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: working register, multiplier accumulator and the
// one-step rotate / shift / shift-add logic. Control (when to load, when to
// step, how many steps) lives in the parent.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic [WIDTH-1:0] step_result
);

    logic [2:0]       op_q;
    logic [WIDTH-1:0] work;        // operand being rotated/shifted; multiplicand for MUL
    logic [WIDTH-1:0] acc;         // MUL partial product
    logic [WIDTH-1:0] mplier;      // MUL multiplier, consumed LSB first
    logic             shift_right; // SHIFT direction, from the sign of the amount
    logic [WIDTH-1:0] work_next;
    logic [WIDTH-1:0] acc_next;

    // One iteration of the selected op; step_result is the value after this step
    always_comb begin
        work_next = work;
        acc_next  = acc;
        case (op_q)
            OP_ROR:   work_next = {work[0], work[WIDTH-1:1]};
            OP_SRA:   work_next = {work[WIDTH-1], work[WIDTH-1:1]};
            OP_SHIFT: work_next = shift_right ? {1'b0, work[WIDTH-1:1]}
                                              : {work[WIDTH-2:0], 1'b0};
            OP_MUL: begin
                acc_next  = acc + (mplier[0] ? work : '0);
                work_next = {work[WIDTH-2:0], 1'b0};
            end
            default: ;
        endcase
        step_result = (op_q == OP_MUL) ? acc_next : work_next;
    end

    // Load operands at acceptance, then advance one step per cycle while stepping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= OP_FWD;
            work        <= '0;
            acc         <= '0;
            mplier      <= '0;
            shift_right <= 1'b0;
        end else if (load) begin
            op_q        <= op;
            work        <= data1;
            acc         <= '0;
            mplier      <= data2;
            shift_right <= data2[WIDTH-1];
        end else if (step) begin
            work        <= work_next;
            acc         <= acc_next;
            mplier      <= {1'b0, mplier[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with START/BUSY/DONE handshake. Single-cycle ops and
// zero-length iterative ops complete on the accepting edge; other iterative
// ops run one bit per cycle in alu_iter_unit.
//
// Handshake: START is sampled on a rising edge only while BUSY=0 (IDLE);
// SELECT/DATA1/DATA2 are captured on that same edge and may change afterwards.
// BUSY is high for exactly k cycles after acceptance. DONE is a one-cycle
// pulse that coincides with BUSY falling (or follows the accepting edge when
// k=0); RESULT/ZERO are valid while DONE is high and held until the next DONE.
// A START presented during the DONE cycle is accepted, allowing back-to-back ops.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             BUSY,
    output logic             DONE,
    output state_t           dbg_state
);

    localparam int               LOG_W   = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] k_start;
    logic [WIDTH-1:0] quick_result;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] shift_mag;
    logic [WIDTH-1:0] step_result;
    logic             zero_lat;
    logic             accept;
    logic             accept_quick;
    logic             last_step;

    assign sum          = DATA1 + DATA2;
    assign accept       = (state == IDLE) && START;
    assign accept_quick = accept && (k_start == '0);
    assign last_step    = (state == RUN) && (cnt == CNT_W'(1));
    assign dbg_state    = state;

    // Iteration count and single-cycle result for the operands on the inputs
    always_comb begin
        shift_mag    = DATA2[WIDTH-1] ? -DATA2 : DATA2;
        k_start      = '0;
        quick_result = DATA1;
        case (SELECT)
            OP_FWD:   quick_result = DATA2;
            OP_ADD:   quick_result = sum;
            OP_AND:   quick_result = DATA1 & DATA2;
            OP_OR:    quick_result = DATA1 | DATA2;
            OP_ROR:   k_start = {1'b0, DATA2[LOG_W-1:0]};
            OP_MUL:   k_start = WIDTH_C;
            OP_SRA:   k_start = (DATA2 >= WIDTH_V) ? WIDTH_C : {1'b0, DATA2[LOG_W-1:0]};
            OP_SHIFT: k_start = (shift_mag >= WIDTH_V) ? WIDTH_C : {1'b0, shift_mag[LOG_W-1:0]};
            default:  ;
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (START && (k_start != '0)) state_next = RUN;
            RUN:  if (cnt == CNT_W'(1))         state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        BUSY = (state == RUN);
    end

    // Remaining-iteration counter, loaded at acceptance
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)              cnt <= '0;
        else if (accept)        cnt <= k_start;
        else if (state == RUN)  cnt <= cnt - CNT_W'(1);
    end

    // ZERO flag for the captured operands, reported when the op completes
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)       zero_lat <= 1'b0;
        else if (accept) zero_lat <= (sum == '0);
    end

    // Result, flag and DONE pulse registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RESULT <= '0;
            ZERO   <= 1'b0;
            DONE   <= 1'b0;
        end else if (accept_quick) begin
            RESULT <= quick_result;
            ZERO   <= (sum == '0);
            DONE   <= 1'b1;
        end else if (last_step) begin
            RESULT <= step_result;
            ZERO   <= zero_lat;
            DONE   <= 1'b1;
        end else begin
            DONE   <= 1'b0;
        end
    end

    alu_iter_unit #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk         (CLK),
        .rst         (RESET),
        .load        (accept && (k_start != '0)),
        .step        (state == RUN),
        .op          (SELECT),
        .data1       (DATA1),
        .data2       (DATA2),
        .step_result (step_result)
    );

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=8).
module tb_seq_alu;
    import alu_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       START;
    logic [2:0] SELECT;
    logic [7:0] DATA1;
    logic [7:0] DATA2;
    logic [7:0] RESULT;
    logic       ZERO;
    logic       BUSY;
    logic       DONE;
    state_t     dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    seq_alu #(.WIDTH(8)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .SELECT    (SELECT),
        .DATA1     (DATA1),
        .DATA2     (DATA2),
        .RESULT    (RESULT),
        .ZERO      (ZERO),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble the inputs after acceptance, wait (bounded) for
    // DONE and check latency, BUSY duration, RESULT and ZERO.
    task automatic run_op(input string tag, input logic [2:0] sel, input logic [7:0] d1,
                          input logic [7:0] d2, input int exp_lat, input logic [7:0] exp_res,
                          input logic exp_zero);
        int lat;
        int busy_cycles;
        lat = 0;
        busy_cycles = 0;
        @(negedge CLK);
        SELECT = sel; DATA1 = d1; DATA2 = d2; START = 1'b1;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(posedge CLK); #1;
            if (i == 1) begin
                START  = 1'b0;
                SELECT = 3'($urandom_range(0, 7));
                DATA1  = 8'($urandom_range(0, 255));
                DATA2  = 8'($urandom_range(0, 255));
            end
            if (DONE) lat = i;
            else if (BUSY) busy_cycles++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy"}, busy_cycles, exp_lat - 1);
        check({tag, "_result"}, RESULT, exp_res);
        check({tag, "_zero"}, ZERO, exp_zero);
    endtask

    initial begin
        int lat;
        int done_cnt;
        RESET = 1'b1; START = 1'b0; SELECT = '0; DATA1 = '0; DATA2 = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_result", RESULT, 8'h00);
        check("rst_zero",   ZERO,   1'b0);
        check("rst_busy",   BUSY,   1'b0);
        check("rst_done",   DONE,   1'b0);
        check("rst_state",  dbg_state, IDLE);
        @(negedge CLK);
        RESET = 1'b0;

        // Single-cycle ops
        run_op("add_1_3",   OP_ADD, 8'h01, 8'h03, 1, 8'h04, 1'b0);
        run_op("add_wrap",  OP_ADD, 8'h05, 8'hFB, 1, 8'h00, 1'b1);
        run_op("fwd",       OP_FWD, 8'h00, 8'h5A, 1, 8'h5A, 1'b0);
        run_op("or",        OP_OR,  8'h0F, 8'h30, 1, 8'h3F, 1'b0);

        // Rotate
        run_op("ror_3",     OP_ROR, 8'h81, 8'h03, 4, 8'h30, 1'b0);
        run_op("ror_8",     OP_ROR, 8'h81, 8'h08, 1, 8'h81, 1'b0);

        // Multiply
        run_op("mul_d_b",   OP_MUL, 8'h0D, 8'h0B, 9, 8'h8F, 1'b0);
        run_op("mul_ovf",   OP_MUL, 8'h20, 8'h10, 9, 8'h00, 1'b0);

        // Arithmetic shift
        run_op("sra_2",     OP_SRA, 8'h90, 8'h02, 3, 8'hE4, 1'b0);
        run_op("sra_200",   OP_SRA, 8'h90, 8'hC8, 9, 8'hFF, 1'b0);
        run_op("sra_0",     OP_SRA, 8'h90, 8'h00, 1, 8'h90, 1'b0);
        run_op("sra_pos_8", OP_SRA, 8'h70, 8'h08, 9, 8'h00, 1'b0);

        // Signed-amount logical shift
        run_op("shift_m3",  OP_SHIFT, 8'h81, 8'hFD, 4, 8'h10, 1'b0);
        run_op("shift_p1",  OP_SHIFT, 8'h81, 8'h01, 2, 8'h02, 1'b0);
        run_op("shift_p8",  OP_SHIFT, 8'hFF, 8'h08, 9, 8'h00, 1'b0);
        run_op("shift_min", OP_SHIFT, 8'h80, 8'h80, 9, 8'h00, 1'b1);

        // START while BUSY is ignored
        @(negedge CLK);
        SELECT = OP_MUL; DATA1 = 8'h0D; DATA2 = 8'h0B; START = 1'b1;
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(posedge CLK); #1;
            if (DONE) lat = i;
            else if (i == 1) START = 1'b0;
            else if (i == 3) begin
                START = 1'b1; SELECT = OP_ADD; DATA1 = 8'h01; DATA2 = 8'h03;
            end else if (i == 4) START = 1'b0;
        end
        check("ign_latency", lat, 9);
        check("ign_result",  RESULT, 8'h8F);
        check("ign_zero",    ZERO, 1'b0);
        @(posedge CLK); #1;
        check("ign_no_extra_done", DONE, 1'b0);

        // RESET in the middle of a MUL
        @(negedge CLK);
        SELECT = OP_MUL; DATA1 = 8'h0D; DATA2 = 8'h0B; START = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge CLK); #1;
            if (i == 1) START = 1'b0;
        end
        check("abort_busy_before", BUSY, 1'b1);
        RESET = 1'b1;
        #1;
        check("abort_result", RESULT, 8'h00);
        check("abort_zero",   ZERO,   1'b0);
        check("abort_busy",   BUSY,   1'b0);
        check("abort_done",   DONE,   1'b0);
        check("abort_state",  dbg_state, IDLE);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            if (DONE) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_idle_busy", BUSY, 1'b0);
        run_op("post_rst_add", OP_ADD, 8'h01, 8'h03, 1, 8'h04, 1'b0);

        // Back-to-back: AND accepted in the ROR DONE cycle
        @(negedge CLK);
        SELECT = OP_ROR; DATA1 = 8'h81; DATA2 = 8'h02; START = 1'b1;
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(posedge CLK); #1;
            if (i == 1) START = 1'b0;
            if (DONE) lat = i;
        end
        check("b2b_ror_latency", lat, 3);
        check("b2b_ror_result",  RESULT, 8'h60);
        SELECT = OP_AND; DATA1 = 8'hF0; DATA2 = 8'h3C; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        check("b2b_and_done",   DONE, 1'b1);
        check("b2b_and_result", RESULT, 8'h30);
        check("b2b_and_zero",   ZERO, 1'b0);
        @(posedge CLK); #1;
        check("b2b_done_drop",  DONE, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
